// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [BE_W-1:0] WE_NONE = 4'b0000;
  localparam logic [BE_W-1:0] WE_B0   = 4'b0001;
  localparam logic [BE_W-1:0] WE_H0   = 4'b0011;
  localparam logic [BE_W-1:0] WE_W    = 4'b1111;

  // Low-lane write-enable pattern for a direct (offset 0) store.
  function automatic logic [BE_W-1:0] we_for_size(input logic [1:0] size);
    logic [BE_W-1:0] we;
    unique case (size)
      SIZE_BYTE: we = WE_B0;
      SIZE_HALF: we = WE_H0;
      SIZE_WORD: we = WE_W;
      default:   we = WE_NONE;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper: request decode (misalignment / RMW
// detection), load lane extraction with extension, and RMW lane merge.
// Build option: LSU_RMW_EN enables read-modify-write for sub-word stores
// at non-zero offsets; when undefined those stores are rejected.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  req_offset,
  input  logic [1:0]  req_size,
  input  logic        req_we,
  input  logic [1:0]  lat_offset,
  input  logic [1:0]  lat_size,
  input  logic        lat_unsigned,
  input  logic [15:0] lat_wdata,
  input  logic [31:0] rdata,
  output logic        err_c,
  output logic        rmw_c,
  output logic [31:0] load_data_c,
  output logic [31:0] merge_data_c
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign shamt   = {lat_offset, 3'b000};
  assign shifted = rdata >> shamt;

  // Classify a new request: rejected, read-modify-write, or plain access.
  always_comb begin
    err_c = 1'b0;
    rmw_c = 1'b0;
    unique case (req_size)
      SIZE_BYTE: begin
        if (req_we && (req_offset != 2'b00)) begin
`ifdef LSU_RMW_EN
          rmw_c = 1'b1;
`else
          err_c = 1'b1;
`endif
        end
      end
      SIZE_HALF: begin
        if (req_offset[0]) begin
          err_c = 1'b1;
        end else if (req_we && req_offset[1]) begin
`ifdef LSU_RMW_EN
          rmw_c = 1'b1;
`else
          err_c = 1'b1;
`endif
        end
      end
      SIZE_WORD: err_c = (req_offset != 2'b00);
      default:   err_c = 1'b1;
    endcase
  end

  // Pick the addressed lane(s) out of the read word and extend.
  always_comb begin
    load_data_c = rdata;
    unique case (lat_size)
      SIZE_BYTE: load_data_c = lat_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data_c = lat_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_data_c = rdata;
    endcase
  end

  // Replace the target lane(s) of the captured word with store data.
  always_comb begin
    if (lat_size == SIZE_HALF) begin
      lane_mask = 32'h0000_FFFF << shamt;
      lane_data = {16'h0, lat_wdata} << shamt;
    end else begin
      lane_mask = 32'h0000_00FF << shamt;
      lane_data = {24'h0, lat_wdata[7:0]} << shamt;
    end
    merge_data_c = (rdata & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving the data port of the dual-port RAM.
// One request in flight; sub-word stores at non-zero offsets use
// read-modify-write when built with LSU_RMW_EN, otherwise they are rejected.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state, state_next;
  logic        accept;

  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_we;
  logic [15:0] lat_wdata;

  logic        dec_err, dec_rmw;
  logic [31:0] load_data, merge_data;

  logic        mem_en_d, rsp_valid_d, rsp_err_d;
  logic [3:0]  mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d, rsp_rdata_d;

  assign accept = req_valid_i && (state == IDLE);

  lsu_align u_align (
    .req_offset   (req_addr_i[1:0]),
    .req_size     (req_size_i),
    .req_we       (req_we_i),
    .lat_offset   (lat_addr[1:0]),
    .lat_size     (lat_size),
    .lat_unsigned (lat_unsigned),
    .lat_wdata    (lat_wdata),
    .rdata        (mem_rdata_i),
    .err_c        (dec_err),
    .rmw_c        (dec_rmw),
    .load_data_c  (load_data),
    .merge_data_c (merge_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (dec_err)                     state_next = RESP;
          else if (req_we_i && !dec_rmw)   state_next = WRITE;
          else                             state_next = READ;
        end
      end
      READ:    state_next = lat_we ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, so they line up with the state entered.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = WE_NONE;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = {req_addr_i[31:2], 2'b00};
            if (req_we_i && !dec_rmw) begin
              mem_we_d    = we_for_size(req_size_i);
              mem_wdata_d = req_wdata_i;
            end
          end
        end
      end
      READ: begin
        if (lat_we) begin
          mem_en_d    = 1'b1;
          mem_we_d    = WE_W;
          mem_addr_d  = {lat_addr[31:2], 2'b00};
          mem_wdata_d = merge_data;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WRITE:   rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Request capture and output registers.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= WE_NONE;
      mem_wdata_o  <= '0;
    end else begin
      if (accept) begin
        lat_addr     <= req_addr_i;
        lat_size     <= req_size_i;
        lat_unsigned <= req_unsigned_i;
        lat_we       <= req_we_i;
        lat_wdata    <= req_wdata_i[15:0];
      end
      req_ready_o <= (state_next == IDLE);
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_err_o   <= rsp_err_d;
      mem_addr_o  <= mem_addr_d;
      mem_en_o    <= mem_en_d;
      mem_we_o    <= mem_we_d;
      mem_wdata_o <= mem_wdata_d;
    end
  end

endmodule
